pipe_cla_addsub: RTL and testbench
==================================

# pipe_cla_addsub

Parametrised, pipelined carry-lookahead adder/subtractor with a valid/ready stream interface. It generalises the team's single-cycle N-bit CLA cell. The operand is split into BLOCK-bit groups, and one group is resolved per pipeline stage with group generate/propagate lookahead. The carry is registered between stages, so the block sustains one operation per clock at high NBIT. It sits between an operand-producing datapath and any consumer that can apply back-pressure.

## Interface
- NBIT, 16: operand/result width; must be an integer multiple of BLOCK (elaboration error otherwise).
- BLOCK, 4: lookahead group width per stage, ≥1; NSTG = NBIT/BLOCK pipeline stages.
- clk  in  1  single clock, all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  input operation present.
- in_ready  out  1  block can accept this cycle.
- a  in  NBIT  operand A.
- b  in  NBIT  operand B.
- cin  in  1  carry-in (borrow-in when sub=1, see Operation).
- sub  in  1  0 = add, 1 = subtract.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- s  out  NBIT  sum/difference.
- cout  out  1  carry-out of MSB (for sub: 1 = no borrow).
- ovf  out  1  signed two's-complement overflow.

## Operation
- Effective operands: b_eff = b XOR {NBIT{sub}}, cin_eff = cin XOR sub.
  - sub=1, cin=0 → a − b.
  - sub=1, cin=1 → a − b − 1.
- Result: {cout, s} = a + b_eff + cin_eff, mod 2^(NBIT+1). No saturation.
- ovf = carry into bit NBIT−1 XOR cout.
- Stage k (k = 0..NSTG−1) resolves bits [k·BLOCK +: BLOCK]:
  - bit p = a|b_eff, g = a&b_eff.
  - Group G/P by lookahead; group carry-out = G | P&c_in.
  - In-group sums from per-bit carries.
- Stage registers per stage: valid bit, registered carry, resolved low result bits, unresolved high a/b_eff bits, MSB carry-in (for ovf, captured in last stage).
- Stage 0 captures a, b_eff, cin_eff on the accept edge and resolves group 0 in that register update.
- Flow control: global advance = !out_valid | out_ready.
  - All stages shift together when advance=1; all hold when advance=0.
  - Bubbles (valid=0) shift through like data.
- in_ready = advance (combinational from out_valid, out_ready).
- Accept: in_valid & in_ready at a rising edge. in_valid without in_ready is ignored; the source must hold its data.
- Output stable (s, cout, ovf unchanged) while out_valid=1 & out_ready=0.
- Ordering strictly FIFO; no drop, no duplication.

## Timing
- Latency: a transaction accepted at edge t has out_valid=1 after edge t+NSTG−1 when never stalled (NSTG=4: visible 3 cycles after accept, i.e. in the 4th register stage).
- Each stall cycle adds exactly 1 cycle of latency.
- Throughput: 1 op/clock with out_ready held high.
- Capacity: NSTG operations in flight. in_ready falls only when out_valid=1 & out_ready=0.
- Reset (rst_n=0 at an edge):
  - All stage valid bits clear; out_valid=0, s=0, cout=0, ovf=0.
  - in_ready=1 in the cycle after reset.
  - In-flight operations are discarded, including mid-stall.
  - Reset overrides a simultaneous accept.
- Simultaneous accept and output pop in a cycle with a full pipe is legal: advance=1, both occur.
- Degenerate BLOCK=NBIT: NSTG=1, single-stage registered CLA, latency 1 edge.

## Test plan
All cases use NBIT=16, BLOCK=4 unless stated.
- Add wrap: a=0xFFFF, b=0x0001, cin=0, sub=0 → s=0x0000, cout=1, ovf=0; out_valid exactly NSTG−1 cycles after accept.
- Signed overflow: a=0x7FFF, b=0x0001, sub=0 → s=0x8000, cout=0, ovf=1. Also a=0x8000, b=0x8000 → s=0x0000, cout=1, ovf=1.
- Subtract: a=0x0005, b=0x0007, sub=1, cin=0 → s=0xFFFE, cout=0, ovf=0. Same with cin=1 → s=0xFFFD. a=0x8000, b=0x0001, sub=1 → s=0x7FFF, ovf=1.
- Back-pressure: 8 back-to-back ops (a=i, b=0x1000·i), out_ready low for 3 cycles mid-stream.
  - Results appear in order, each held stable during the stall; none lost.
  - in_ready=0 exactly during the stall cycles where out_valid=1.
- Reset mid-flight: assert rst_n=0 for 1 cycle with 3 ops in the pipe.
  - All outputs 0 and out_valid=0 afterwards; the next accepted op emerges alone after the nominal latency.
- Random: 10k ops with random valid/ready toggling, also at NBIT=32/BLOCK=8 and NBIT=8/BLOCK=8.
  - Scoreboard against the integer model (a + b_eff + cin_eff) for s, cout, ovf, in order.

Source files
------------

// File: rtl/pipe_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor: one BLOCK-bit lookahead group
// resolved per stage, carry registered between stages, valid/ready stream I/O.
module pipe_cla_addsub #(
    parameter int unsigned NBIT  = 16,
    parameter int unsigned BLOCK = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [NBIT-1:0] a,
    input  logic [NBIT-1:0] b,
    input  logic            cin,
    input  logic            sub,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [NBIT-1:0] s,
    output logic            cout,
    output logic            ovf
);

    localparam int unsigned NSTG = NBIT / BLOCK;

    if ((BLOCK == 0) || ((NBIT % BLOCK) != 0)) begin : g_bad_param
        $error("pipe_cla_addsub: NBIT must be a non-zero multiple of BLOCK");
    end

    // Group lookahead: prefix G/P per bit gives every in-group carry from c0.
    function automatic logic [BLOCK:0] cla_grp(
        input logic [BLOCK-1:0] ga,
        input logic [BLOCK-1:0] gb,
        input logic             c0
    );
        logic [BLOCK:0]   c;
        logic [BLOCK-1:0] sum;
        logic             gg;
        logic             pg;
        c    = '0;
        c[0] = c0;
        sum  = '0;
        gg   = 1'b0;
        pg   = 1'b1;
        for (int unsigned i = 0; i < BLOCK; i++) begin
            sum[i]  = ga[i] ^ gb[i] ^ c[i];
            gg      = (ga[i] & gb[i]) | ((ga[i] | gb[i]) & gg);
            pg      = (ga[i] | gb[i]) & pg;
            c[i+1]  = gg | (pg & c0);
        end
        return {c[BLOCK], sum};
    endfunction

    logic adv_c;

    assign adv_c    = !out_valid || out_ready;
    assign in_ready = adv_c;

    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        // Operand window still unresolved when entering stage k.
        localparam int unsigned UW = NBIT - k * BLOCK;
        localparam int unsigned RW = (k + 1) * BLOCK;

        logic          sv;
        logic          sc;
        logic [UW-1:0] ua;
        logic [UW-1:0] ub;
        logic [BLOCK:0] grp;
        logic [RW-1:0] res_n;
        logic          vld;
        logic          cy;
        logic [RW-1:0] res;

        if (k == 0) begin : g_src
            assign sv    = in_valid;
            assign sc    = cin ^ sub;
            assign ua    = a;
            assign ub    = b ^ {NBIT{sub}};
            assign res_n = grp[BLOCK-1:0];
        end else begin : g_src
            assign sv    = g_stg[k-1].vld;
            assign sc    = g_stg[k-1].cy;
            assign ua    = g_stg[k-1].g_op.opa;
            assign ub    = g_stg[k-1].g_op.opb;
            assign res_n = {grp[BLOCK-1:0], g_stg[k-1].res};
        end

        assign grp = cla_grp(ua[BLOCK-1:0], ub[BLOCK-1:0], sc);

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                vld <= 1'b0;
                cy  <= 1'b0;
                res <= '0;
            end else if (adv_c) begin
                vld <= sv;
                cy  <= grp[BLOCK];
                res <= res_n;
            end
        end

        if (k < NSTG - 1) begin : g_op
            logic [UW-BLOCK-1:0] opa;
            logic [UW-BLOCK-1:0] opb;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    opa <= '0;
                    opb <= '0;
                end else if (adv_c) begin
                    opa <= ua[UW-1:BLOCK];
                    opb <= ub[UW-1:BLOCK];
                end
            end
        end else begin : g_ovf
            // Carry into the MSB recovered as sum ^ a ^ b_eff at the top bit.
            logic ovf_q;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (adv_c) begin
                    ovf_q <= grp[BLOCK] ^ grp[BLOCK-1] ^ ua[BLOCK-1] ^ ub[BLOCK-1];
                end
            end
        end
    end

    assign out_valid = g_stg[NSTG-1].vld;
    assign s         = g_stg[NSTG-1].res;
    assign cout      = g_stg[NSTG-1].cy;
    assign ovf       = g_stg[NSTG-1].g_ovf.ovf_q;

endmodule

// File: tb/tb_pipe_cla_addsub.sv
// Bench for pipe_cla_addsub: directed vectors, back-pressure, reset, and
// randomized scoreboard runs at 16/4, 32/8 and 8/8.
module tb_pipe_cla_addsub;

    localparam int unsigned NBIT  = 16;
    localparam int unsigned BLOCK = 4;
    localparam int unsigned NSTG  = NBIT / BLOCK;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [NBIT-1:0] a;
    logic [NBIT-1:0] b;
    logic            cin;
    logic            sub;
    logic            out_valid;
    logic            out_ready;
    logic [NBIT-1:0] s;
    logic            cout;
    logic            ovf;
    logic            rand_go;

    int checks;
    int errors;

    pipe_cla_addsub #(.NBIT(NBIT), .BLOCK(BLOCK)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .s(s), .cout(cout), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: {ovf, cout, s} from plain integer arithmetic.
    function automatic logic [17:0] model16(input logic [15:0] ma, input logic [15:0] mb,
                                            input logic mc, input logic ms);
        logic [15:0] be;
        logic [16:0] sum;
        logic        v;
        be  = ms ? ~mb : mb;
        sum = 17'(ma) + 17'(be) + 17'(mc ^ ms);
        v   = (ma[15] == be[15]) && (sum[15] != ma[15]);
        return {v, sum};
    endfunction

    // Scoreboard monitor for the main instance.
    logic [17:0] exp_q[$];
    logic        hold;
    logic [17:0] held;
    int          n_pop;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            hold = 1'b0;
        end else begin
            chk("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
            if (hold) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_data", 64'({ovf, cout, s}), 64'(held));
            end
            if (out_valid && out_ready) begin
                n_pop++;
                chk("queue_nonempty", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0)
                    chk("result", 64'({ovf, cout, s}), 64'(exp_q.pop_front()));
            end
            if (in_valid && in_ready)
                exp_q.push_back(model16(a, b, cin, sub));
            hold = out_valid && !out_ready;
            held = {ovf, cout, s};
        end
    end

    // Extra configurations, each with its own random driver and scoreboard.
    for (genvar gi = 0; gi < 2; gi++) begin : g_x
        localparam int unsigned NB  = (gi == 0) ? 32 : 8;
        localparam int unsigned NB1 = NB + 1;
        localparam int unsigned BL  = 8;

        logic          iv, ir, ov, ordy, ci, sb, co, of, done;
        logic [NB-1:0] xa, xb, xs;
        logic [NB+1:0] q[$];
        logic          xhold;
        logic [NB+1:0] xheld;
        int            n_acc;
        int            n_xpop;

        pipe_cla_addsub #(.NBIT(NB), .BLOCK(BL)) u_dut (
            .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir),
            .a(xa), .b(xb), .cin(ci), .sub(sb), .out_valid(ov),
            .out_ready(ordy), .s(xs), .cout(co), .ovf(of)
        );

        always @(negedge clk) begin : mon
            logic [NB-1:0] be;
            logic [NB:0]   sum;
            if (!rst_n) begin
                q.delete();
                xhold = 1'b0;
            end else begin
                chk("x_in_ready", 64'(ir), 64'(!ov || ordy));
                if (xhold)
                    chk("x_hold", 64'({ov, of, co, xs}), 64'({1'b1, xheld}));
                if (ov && ordy) begin
                    n_xpop++;
                    chk("x_queue_nonempty", 64'(q.size() != 0), 64'd1);
                    if (q.size() != 0)
                        chk("x_result", 64'({of, co, xs}), 64'(q.pop_front()));
                end
                if (iv && ir) begin
                    be  = sb ? ~xb : xb;
                    sum = NB1'(xa) + NB1'(be) + NB1'(ci ^ sb);
                    q.push_back({(xa[NB-1] == be[NB-1]) && (sum[NB-1] != xa[NB-1]), sum});
                end
                xhold = ov && !ordy;
                xheld = {of, co, xs};
            end
        end

        initial begin : drv
            logic acc;
            iv = 1'b0; ordy = 1'b1; ci = 1'b0; sb = 1'b0;
            xa = '0; xb = '0; done = 1'b0; n_acc = 0; n_xpop = 0;
            wait (rand_go);
            @(posedge clk); #1;
            for (int c = 0; c < 20000 && n_acc < 2000; c++) begin
                @(negedge clk);
                acc = iv && ir;
                @(posedge clk); #1;
                if (acc) n_acc++;
                if (acc || !iv) begin
                    iv = ($urandom_range(0, 3) != 0) && (n_acc < 2000);
                    xa = NB'($urandom);
                    xb = NB'($urandom);
                    ci = 1'($urandom);
                    sb = 1'($urandom);
                end
                ordy = ($urandom_range(0, 3) != 0);
            end
            iv = 1'b0; ordy = 1'b1;
            repeat (NB / BL + 3) @(posedge clk);
            #1 done = 1'b1;
        end
    end

    // Single op on an idle pipe: checks first-valid latency and the value.
    task automatic single(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                          input logic tc, input logic ts, input logic [17:0] exp);
        int n;
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid = 1'b1; a = ta; b = tb; cin = tc; sub = ts;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (n = 0; n < 20; n++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        chk({tag, "_latency"}, 64'(n), 64'(NSTG - 1));
        chk(tag, 64'({ovf, cout, s}), 64'(exp));
    endtask

    initial begin : main
        int  i, c, low, pop0, acc_n;
        logic acc;
        checks = 0; errors = 0; n_pop = 0; rand_go = 1'b0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", 64'({ovf, cout, s}), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1 rst_n = 1'b1;

        single("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h0000});
        single("ovf_pos",  16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h8000});
        single("ovf_neg",  16'h8000, 16'h8000, 1'b0, 1'b0, {1'b1, 1'b1, 16'h0000});
        single("sub",      16'h0005, 16'h0007, 1'b0, 1'b1, {1'b0, 1'b0, 16'hFFFE});
        single("sub_brw",  16'h0005, 16'h0007, 1'b1, 1'b1, {1'b0, 1'b0, 16'hFFFD});
        single("sub_ovf",  16'h8000, 16'h0001, 1'b0, 1'b1, {1'b1, 1'b1, 16'h7FFF});

        // Back-pressure: 8 back-to-back ops, consumer stalls for 3 cycles.
        @(posedge clk); #1;
        i = 0; low = 0; pop0 = n_pop;
        for (c = 0; c < 40; c++) begin
            out_ready = !(c >= 5 && c < 8);
            in_valid  = (i < 8);
            a = 16'(i); b = 16'(i << 12); cin = 1'b0; sub = 1'b0;
            @(negedge clk);
            if (!in_ready) low++;
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) i++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("bp_ready_low", 64'(low), 64'd3);
        chk("bp_pops", 64'(n_pop - pop0), 64'd8);
        chk("bp_drained", 64'(exp_q.size()), 64'd0);

        // Reset with 3 ops in flight and a simultaneous accept attempt.
        for (int j = 0; j < 3; j++) begin
            in_valid = 1'b1; a = 16'(j + 1); b = 16'h0100;
            @(posedge clk); #1;
        end
        rst_n = 1'b0; a = 16'h0ABC;
        @(posedge clk); #1;
        rst_n = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_data", 64'({ovf, cout, s}), 64'd0);
        chk("mid_rst_ready", 64'(in_ready), 64'd1);
        low = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) low++;
        end
        chk("mid_rst_leak", 64'(low), 64'd0);
        single("post_rst", 16'h1234, 16'h1111, 1'b0, 1'b0, {1'b0, 1'b0, 16'h2345});

        // Random stream on the main instance, extras run concurrently.
        rand_go = 1'b1;
        @(posedge clk); #1;
        acc_n = 0; pop0 = n_pop;
        in_valid = 1'b0;
        for (c = 0; c < 40000 && acc_n < 6000; c++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) acc_n++;
            if (acc || !in_valid) begin
                in_valid = ($urandom_range(0, 3) != 0) && (acc_n < 6000);
                a = 16'($urandom); b = 16'($urandom);
                cin = 1'($urandom); sub = 1'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (NSTG + 3) @(posedge clk);
        @(negedge clk);
        chk("rand_accepted", 64'(acc_n), 64'd6000);
        chk("rand_pops", 64'(n_pop - pop0), 64'd6000);
        chk("rand_drained", 64'(exp_q.size()), 64'd0);

        for (int t = 0; t < 50000 && !(g_x[0].done && g_x[1].done); t++) @(posedge clk);
        @(negedge clk);
        chk("x32_done", 64'(g_x[0].done), 64'd1);
        chk("x8_done", 64'(g_x[1].done), 64'd1);
        chk("x32_pops", 64'(g_x[0].n_xpop), 64'd2000);
        chk("x8_pops", 64'(g_x[1].n_xpop), 64'd2000);
        chk("x32_drained", 64'(g_x[0].q.size()), 64'd0);
        chk("x8_drained", 64'(g_x[1].q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
